// File: rtl/nn_layer_sequencer.sv
// Sequencer for one fully-connected layer on a shared fixed-point MAC: optional weight fill,
// then per neuron MAC over all inputs, bias add, external activation and output write.
module nn_layer_sequencer #(
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 2,
   parameter int DW      = 8,
   parameter int FRAC    = 4,
   localparam int IAW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int WAW    = (NUM_IN * NUM_OUT > 1) ? $clog2(NUM_IN * NUM_OUT) : 1,
   localparam int OAW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 reload,
   output logic                 busy,
   output logic                 done,
   output logic                 fill,
   input  logic                 fill_ack,
   output logic [IAW-1:0]       in_addr,
   input  logic signed [DW-1:0] in_data,
   output logic [WAW-1:0]       w_addr,
   input  logic signed [DW-1:0] w_data,
   output logic [OAW-1:0]       b_addr,
   input  logic signed [DW-1:0] b_data,
   output logic signed [DW-1:0] z_value,
   input  logic signed [DW-1:0] a_value,
   output logic                 out_we,
   output logic [OAW-1:0]       out_addr,
   output logic signed [DW-1:0] out_data
);

   localparam logic [IAW-1:0] I_LAST = IAW'(NUM_IN - 1);
   localparam logic [OAW-1:0] J_LAST = OAW'(NUM_OUT - 1);

   typedef enum logic [2:0] {
      StIdle, StFill, StMac, StTail, StBias, StAct, StDone
   } state_t;

   state_t                state_q;
   logic                  loaded_q;
   logic [IAW-1:0]        i_q;
   logic [OAW-1:0]        j_q;
   logic signed [DW-1:0]  acc_q;

   logic signed [2*DW-1:0] w_ext, x_ext, prod;
   logic signed [DW-1:0]   prod_p;

   // Full-width signed product, floor-shifted, then wrapped back to DW bits.
   assign w_ext  = {{DW{w_data[DW-1]}}, w_data};
   assign x_ext  = {{DW{in_data[DW-1]}}, in_data};
   assign prod   = w_ext * x_ext;
   assign prod_p = DW'(prod >>> FRAC);

   // Activation is combinational on z_value, so the write data cannot be registered.
   assign out_data = out_we ? a_value : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         loaded_q <= 1'b0;
         i_q      <= '0;
         j_q      <= '0;
         acc_q    <= '0;
         z_value  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         fill     <= 1'b0;
         out_we   <= 1'b0;
         in_addr  <= '0;
         w_addr   <= '0;
         b_addr   <= '0;
         out_addr <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy <= 1'b1;
                  if (reload || !loaded_q) begin
                     state_q <= StFill;
                     fill    <= 1'b1;
                  end else begin
                     state_q <= StMac;
                     i_q     <= '0;
                     j_q     <= '0;
                     acc_q   <= '0;
                     in_addr <= '0;
                     w_addr  <= '0;
                  end
               end
            end
            StFill: begin
               if (fill_ack) begin
                  state_q  <= StMac;
                  fill     <= 1'b0;
                  loaded_q <= 1'b1;
                  i_q      <= '0;
                  j_q      <= '0;
                  acc_q    <= '0;
                  in_addr  <= '0;
                  w_addr   <= '0;
               end
            end
            StMac: begin
               // Data on the bus belongs to the previous address; none exists for i=0.
               if (i_q != '0) acc_q <= acc_q + prod_p;
               if (i_q == I_LAST) begin
                  state_q <= StTail;
                  b_addr  <= j_q;
               end else begin
                  i_q     <= i_q + 1'b1;
                  in_addr <= i_q + 1'b1;
                  w_addr  <= w_addr + 1'b1;
               end
            end
            StTail: begin
               acc_q   <= acc_q + prod_p;
               state_q <= StBias;
            end
            StBias: begin
               z_value  <= acc_q + b_data;
               state_q  <= StAct;
               out_we   <= 1'b1;
               out_addr <= j_q;
            end
            StAct: begin
               out_we <= 1'b0;
               if (j_q == J_LAST) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end else begin
                  state_q <= StMac;
                  j_q     <= j_q + 1'b1;
                  i_q     <= '0;
                  acc_q   <= '0;
                  in_addr <= '0;
                  w_addr  <= w_addr + 1'b1;
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: 2x2 layer, FRAC=4, identity activation.
module tb_nn_layer_sequencer;

   localparam int NI = 2;
   localparam int NO = 2;

   logic clk = 1'b0;
   logic rst, start, reload, fill_ack;
   logic busy, done, fill, out_we;
   logic [0:0] in_addr, b_addr, out_addr;
   logic [1:0] w_addr;
   logic signed [7:0] in_data, w_data, b_data, z_value, a_value, out_data;

   logic signed [7:0] x_mem [NI];
   logic signed [7:0] w_mem [NI*NO];
   logic signed [7:0] b_mem [NO];

   typedef struct packed {
      logic [0:0]        addr;
      logic signed [7:0] data;
   } wr_t;
   wr_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int fill_lat = 3;
   int fill_cnt = 0;
   bit force_ack = 1'b0;

   nn_layer_sequencer #(.NUM_IN(NI), .NUM_OUT(NO), .DW(8), .FRAC(4)) dut (
      .clk(clk), .rst(rst), .start(start), .reload(reload),
      .busy(busy), .done(done), .fill(fill), .fill_ack(fill_ack),
      .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data), .z_value(z_value), .a_value(a_value),
      .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
   );

   always #5 clk = ~clk;
   assign a_value = z_value;

   always @(posedge clk) begin
      in_data <= x_mem[in_addr];
      w_data  <= w_mem[w_addr];
      b_data  <= b_mem[b_addr];
   end

   // Fill responder: acknowledges once fill has been seen for fill_lat cycles.
   always @(negedge clk) begin
      if (fill) fill_cnt = fill_cnt + 1;
      else      fill_cnt = 0;
      fill_ack = force_ack || (fill && fill_cnt >= fill_lat);
   end

   function automatic logic signed [7:0] model(input int j);
      int acc, pr;
      logic [7:0] t;
      acc = 0;
      for (int i = 0; i < NI; i++) begin
         pr  = int'(w_mem[j*NI+i]) * int'(x_mem[i]);
         pr  = pr >>> 4;
         t   = 8'(acc + pr);
         acc = int'($signed(t));
      end
      t = 8'(acc + int'(b_mem[j]));
      return $signed(t);
   endfunction

   task automatic push_exp(input int a, input logic signed [7:0] d);
      wr_t e;
      e.addr = 1'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic load_basic();
      x_mem[0] = 8'sd16;  x_mem[1] = 8'sd32;
      w_mem[0] = 8'sd16;  w_mem[1] = -8'sd8; w_mem[2] = 8'sd32; w_mem[3] = 8'sd32;
      b_mem[0] = 8'sd5;   b_mem[1] = -8'sd100;
   endtask

   // Runs one layer evaluation; each write is popped from the scoreboard and compared.
   task automatic run_layer(input bit rl, input int pulse_at, output int busy_n,
                            output int fill_n, output int done_n, output int wr_n,
                            output int rise_c);
      wr_t e;
      bit fin;
      busy_n = 0; fill_n = 0; done_n = 0; wr_n = 0; rise_c = -1; fin = 1'b0;
      @(negedge clk);
      start = 1'b1; reload = rl;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         start  = (c == pulse_at);
         reload = 1'b0;
         if (busy) begin
            busy_n++;
            if (rise_c < 0) rise_c = c;
         end
         if (fill) fill_n++;
         if (done) done_n++;
         if (out_we) begin
            wr_n++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d data %0d, none expected",
                        out_addr, out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_addr, out_data} !== {e.addr, e.data}) begin
                  n_fail++;
                  $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                           out_addr, out_data, e.addr, e.data);
               end
            end
         end
         if (!busy && rise_c >= 0) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_timeout: busy=%0b after 300 cycles, expected run to finish", busy);
      end
   endtask

   task automatic check_run(input string name, input int got_busy, input int exp_busy,
                            input int got_fill, input int exp_fill, input int got_done);
      n_checks++;
      if (got_busy !== exp_busy) begin
         n_fail++;
         $display("FAIL %s_length: got %0d busy cycles, expected %0d", name, got_busy, exp_busy);
      end
      n_checks++;
      if (got_fill !== exp_fill) begin
         n_fail++;
         $display("FAIL %s_fill: got %0d fill cycles, expected %0d", name, got_fill, exp_fill);
      end
      n_checks++;
      if (got_done !== 1) begin
         n_fail++;
         $display("FAIL %s_done: got %0d done pulses, expected 1", name, got_done);
      end
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL %s_missing: %0d writes outstanding, expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; reload = 1'b0;
      load_basic();
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, fill, out_we} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy/done/fill/we %b, expected 0000",
                  {busy, done, fill, out_we});
      end
      n_checks++;
      if ({in_addr, w_addr, b_addr, out_addr} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_addr: got %b, expected 0", {in_addr, w_addr, b_addr, out_addr});
      end
      n_checks++;
      if ({z_value, out_data} !== 16'b0) begin
         n_fail++;
         $display("FAIL reset_data: got z %0d out %0d, expected 0 0", z_value, out_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int bn, fn, dn, wn, rc;
      load_basic();
      fill_lat = 3;
      push_exp(0, 8'sd5);
      push_exp(1, -8'sd4);
      run_layer(1'b1, -1, bn, fn, dn, wn, rc);
      n_checks++;
      if (rc !== 0) begin
         n_fail++;
         $display("FAIL basic_busy_rise: busy rose %0d cycles late, expected 0", rc);
      end
      check_run("basic", bn, 14, fn, 3, dn);
   endtask

   task automatic test_restart();
      int bn, fn, dn, wn, rc;
      push_exp(0, 8'sd5);
      push_exp(1, -8'sd4);
      run_layer(1'b0, -1, bn, fn, dn, wn, rc);
      check_run("restart", bn, 11, fn, 0, dn);
   endtask

   task automatic test_wrap();
      int bn, fn, dn, wn, rc;
      x_mem[0] = 8'sd127; x_mem[1] = 8'sd127;
      w_mem[0] = 8'sd127; w_mem[1] = 8'sd127; w_mem[2] = -8'sd1; w_mem[3] = 8'sd0;
      b_mem[0] = 8'sd0;   b_mem[1] = 8'sd0;
      push_exp(0, -8'sd32);
      push_exp(1, -8'sd8);
      run_layer(1'b0, -1, bn, fn, dn, wn, rc);
      check_run("wrap", bn, 11, fn, 0, dn);
      x_mem[0] = 8'sd1;  x_mem[1] = 8'sd0;
      w_mem[0] = -8'sd1; w_mem[1] = 8'sd0; w_mem[2] = 8'sd0; w_mem[3] = 8'sd0;
      push_exp(0, -8'sd1);
      push_exp(1, 8'sd0);
      run_layer(1'b0, -1, bn, fn, dn, wn, rc);
      check_run("floor", bn, 11, fn, 0, dn);
   endtask

   task automatic test_ack_high();
      int bn, fn, dn, wn, rc;
      load_basic();
      force_ack = 1'b1;
      fill_ack  = 1'b1;
      @(negedge clk);
      push_exp(0, 8'sd5);
      push_exp(1, -8'sd4);
      run_layer(1'b1, -1, bn, fn, dn, wn, rc);
      check_run("ack_high", bn, 12, fn, 1, dn);
      force_ack = 1'b0;
   endtask

   task automatic test_mid_reset();
      int bn, fn, dn, wn, rc;
      bit seen0, bad;
      wr_t e;
      load_basic();
      seen0 = 1'b0; bad = 1'b0;
      @(negedge clk);
      start = 1'b1; reload = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_we) begin
            seen0 = 1'b1;
            e.addr = out_addr;
            e.data = out_data;
         end else if (seen0) begin
            break;
         end
      end
      n_checks++;
      if (!seen0 || {e.addr, e.data} !== {1'b0, 8'sd5}) begin
         n_fail++;
         $display("FAIL midrst_first_write: seen %0b addr %0d data %0d, expected 1 0 5",
                  seen0, e.addr, e.data);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, fill, out_we, in_addr, w_addr, b_addr, out_addr, z_value, out_data}
          !== 25'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs: busy %0b we %0b in_addr %0d w_addr %0d z %0d, expected 0",
                  busy, out_we, in_addr, w_addr, z_value);
      end
      repeat (3) begin
         @(negedge clk);
         if (done || out_we) bad = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done || out_we) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL midrst_quiet: got done/out_we after abort, expected none");
      end
      fill_lat = 3;
      push_exp(0, 8'sd5);
      push_exp(1, -8'sd4);
      run_layer(1'b0, -1, bn, fn, dn, wn, rc);
      check_run("after_reset", bn, 14, fn, 3, dn);
   endtask

   task automatic test_start_while_busy();
      int bn, fn, dn, wn, rc;
      load_basic();
      push_exp(0, 8'sd5);
      push_exp(1, -8'sd4);
      run_layer(1'b0, 4, bn, fn, dn, wn, rc);
      n_checks++;
      if (wn !== 2) begin
         n_fail++;
         $display("FAIL busy_start_writes: got %0d writes, expected 2", wn);
      end
      check_run("busy_start", bn, 11, fn, 0, dn);
   endtask

   task automatic test_random();
      int bn, fn, dn, wn, rc;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NI; i++) x_mem[i] = 8'($urandom_range(0, 255));
         for (int i = 0; i < NI*NO; i++) w_mem[i] = 8'($urandom_range(0, 255));
         for (int j = 0; j < NO; j++) b_mem[j] = 8'($urandom_range(0, 255));
         for (int j = 0; j < NO; j++) push_exp(j, model(j));
         run_layer(r[0], -1, bn, fn, dn, wn, rc);
         check_run("random", bn, r[0] ? 14 : 11, fn, r[0] ? 3 : 0, dn);
      end
   endtask

   initial begin
      fill_ack = 1'b0;
      test_reset();
      test_basic();
      test_restart();
      test_wrap();
      test_ack_high();
      test_mid_reset();
      test_start_while_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500000, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Controller that runs one fully-connected layer on a single shared fixed-point multiply-accumulate datapath. It requests a weight/bias fill, then for each output neuron in turn it streams inputs and weights through the MAC, adds the bias, passes the sum through the external activation function and writes the result. It sits between the network-level control (start/done) and the layer's weight, bias, input and output storage.

## Interface
- `NUM_IN`, default 2: inputs per neuron; ≥1.
- `NUM_OUT`, default 2: neurons in the layer; ≥1.
- `DW`, default 8: signed data width for inputs, weights, biases, accumulator and outputs.
- `FRAC`, default 4: fractional bits; each product is shifted right by this amount.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin one layer evaluation; sampled only in IDLE.
- `reload` in 1: force a weight fill even if weights are already loaded; sampled together with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last output has been written.
- `fill` out 1: weight/bias fill request; high throughout FILL.
- `fill_ack` in 1: fill complete; level.
- `in_addr` out clog2(NUM_IN): input read address.
- `in_data` in DW signed: input value, valid one cycle after its address.
- `w_addr` out clog2(NUM_IN*NUM_OUT): weight read address, equal to j*NUM_IN+i.
- `w_data` in DW signed: weight value, valid one cycle after its address.
- `b_addr` out clog2(NUM_OUT): bias read address (j).
- `b_data` in DW signed: bias value, valid one cycle after its address.
- `z_value` out DW signed: registered pre-activation sum fed to the activation function.
- `a_value` in DW signed: combinational activation result of `z_value`.
- `out_we` out 1: output write strobe.
- `out_addr` out clog2(NUM_OUT): output index.
- `out_data` out DW signed: activated output.

## Operation
- **Loaded flag:** `loaded` is set when FILL exits and cleared by reset.
- **IDLE:**
  - If `start` is high and (`reload` is high or `loaded` is low), go to FILL.
  - If `start` is high otherwise, go to MAC with j=0.
  - While busy, `start` is ignored.
- **FILL:**
  - `fill`=1.
  - Exit to MAC (j=0, i=0, acc=0) on the first cycle `fill_ack` is sampled high.
  - FILL lasts at least 1 cycle, even if `fill_ack` is already high on entry.
- **MAC:**
  - Runs NUM_IN cycles, i=0..NUM_IN-1.
  - Drives `in_addr`=i and `w_addr`=j*NUM_IN+i. The weight address is kept as a running counter, not a multiply.
  - One cycle after each address: p = (w_data*in_data) as a 2·DW signed product, then arithmetic right shift by FRAC, then truncate to DW bits. Then acc = acc + p, with DW-bit two's-complement wrap and no saturation.
- **TAIL (1 cycle):** accumulate the last product; drive `b_addr`=j.
- **BIAS (1 cycle):** `z_value` <= acc + b_data, with DW-bit wrap.
- **ACT (1 cycle):**
  - `out_we`=1, `out_addr`=j, `out_data`=a_value.
  - If j==NUM_OUT-1, go to DONE.
  - Otherwise j++, i=0, acc=0, and go to MAC.
- **DONE (1 cycle):** `done`=1, then IDLE.
- **Reset values (asynchronous):** state=IDLE, `loaded`=0, all counters 0, acc=0, `z_value`=0. All outputs are 0: `busy`, `done`, `fill`, `out_we`, `out_data` and all addresses.
- **Reset mid-operation:** aborts immediately. No further `out_we`, and no `done` for the aborted run. `loaded` clears, so the next start always fills.
- **Outside their states:** addresses hold their last value; `out_we`, `fill` and `done` are low.

## Timing
- Memory read latency is exactly 1 cycle; the sequencer does not stall.
- Per neuron: NUM_IN+3 cycles from the first MAC cycle to the `out_we` cycle.
- Run length from the first busy cycle to the `done` cycle:
  - With fill: F + NUM_OUT*(NUM_IN+3) + 1, where F = FILL cycles (≥1).
  - Without fill: NUM_OUT*(NUM_IN+3) + 1.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`.
- `start` may be reasserted in the IDLE cycle that follows DONE.
- `out_data` for neuron j equals the activation of the `z_value` registered in the preceding BIAS cycle.

## Test plan
Unless stated otherwise: NUM_IN=2, NUM_OUT=2, FRAC=4, and the bench uses identity activation (a=z).
- **Basic run:** x=[16,32], w=[16,-8,32,32], b=[5,-100]; start with reload=1, `fill_ack` after 3 cycles.
  - Writes out[0]=5 and out[1]=-4.
  - `done` comes 3+2*5+1 = 14 cycles after `busy` rises.
- **Restart without reload:** same data, start again with reload=0.
  - `fill` is never asserted; identical outputs.
  - `done` comes 11 cycles after `busy` rises.
- **Wrap and negative rounding:**
  - w0=[127,127], x=[127,127], b0=0: out[0]=-32, because 1008 truncates to -16 twice.
  - w=[-1,0], x=[1,0]: p=-1 (floor), out=-1.
- **`fill_ack` already high:** assert `fill_ack` high before start, reload=1.
  - FILL lasts exactly 1 cycle; outputs are correct.
- **Reset mid-MAC of neuron 1:**
  - All outputs are 0 immediately; no `done`.
  - A subsequent start with reload=0 still enters FILL.
- **`start` pulsed while busy:** ignored; exactly 2 writes and 1 `done`.
